// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input loader.
// Contents:
//   DATA_W          - width of x samples and filter taps
//   loader_state_e  - top-level loader states (LOAD, START, RUN)
package conv_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/conv_input_loader_load_channel.sv
// One write channel of the input loader: accepts bytes on a valid/ready
// stream and writes them to consecutive memory addresses 0..N-1.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   s_data_in, s_valid  - input stream data/valid
//   s_ready             - channel accepts a byte this cycle
//   load_en             - high while the loader is in LOAD
//   clear               - releases the channel for a new load
//   rd_addr             - controller read address, used outside LOAD
//   data, addr, wr_en   - memory write interface
//   full                - all N entries of this run written
module load_channel
    import conv_pkg::*;
#(
    parameter int N    = 8,
    parameter int LG_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              load_en,
    input  logic              clear,
    input  logic [LG_N-1:0]   rd_addr,
    output logic [DATA_W-1:0] data,
    output logic [LG_N-1:0]   addr,
    output logic              wr_en,
    output logic              full
);

    // Counter wraps at N-1 even when N is not a power of two.
    localparam logic [LG_N-1:0] LAST = LG_N'(N - 1);

    logic [LG_N-1:0] cnt_r;
    logic            full_r;
    logic            ready_s;
    logic            xfer_s;

    // Handshake, write strobe and address mux (controller owns addr outside LOAD).
    always_comb begin
        ready_s = load_en && !full_r;
        xfer_s  = s_valid && ready_s;
        if (load_en) begin
            addr = cnt_r;
        end else begin
            addr = rd_addr;
        end
    end

    assign s_ready = ready_s;
    assign wr_en   = xfer_s;
    assign data    = s_data_in;
    assign full    = full_r;

    // Write counter and full flag; the last transfer wraps the counter and sets full.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {LG_N{1'b0}};
            full_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= {LG_N{1'b0}};
            full_r <= 1'b0;
        end else if (xfer_s) begin
            if (cnt_r == LAST) begin
                cnt_r  <= {LG_N{1'b0}};
                full_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + LG_N'(1);
                full_r <= full_r;
            end
        end else begin
            cnt_r  <= cnt_r;
            full_r <= full_r;
        end
    end

endmodule

// File: rtl/conv_input_loader.sv
// Write-side front end of the 1-D convolution datapath. Loads DATA_N x
// samples and FILTER_N filter taps into their memories, pulses start once
// both are full, then lends the memory address buses to the controller
// until compute_done.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   s_data_in_x/s_valid_x/s_ready_x    - x sample stream
//   s_data_in_f/s_valid_f/s_ready_f    - filter tap stream
//   rd_addr_x, rd_addr_f               - controller read addresses (START/RUN)
//   compute_done                       - controller releases the memories
//   data_x/addr_x/wr_en_x              - x memory write interface
//   data_f/addr_f/wr_en_f              - f memory write interface
//   start                              - one-cycle pulse, memories loaded
//   busy                               - high in START and RUN
module conv_input_loader
    import conv_pkg::*;
#(
    parameter int DATA_N      = 8,
    parameter int FILTER_N    = 4,
    parameter int LG_DATA_N   = 3,
    parameter int LG_FILTER_N = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      s_data_in_x,
    input  logic                   s_valid_x,
    output logic                   s_ready_x,
    input  logic [DATA_W-1:0]      s_data_in_f,
    input  logic                   s_valid_f,
    output logic                   s_ready_f,
    input  logic [LG_DATA_N-1:0]   rd_addr_x,
    input  logic [LG_FILTER_N-1:0] rd_addr_f,
    input  logic                   compute_done,
    output logic [DATA_W-1:0]      data_x,
    output logic [LG_DATA_N-1:0]   addr_x,
    output logic                   wr_en_x,
    output logic [DATA_W-1:0]      data_f,
    output logic [LG_FILTER_N-1:0] addr_f,
    output logic                   wr_en_f,
    output logic                   start,
    output logic                   busy
);

    loader_state_e state_r;
    loader_state_e state_next_s;
    logic          load_en_s;
    logic          clear_s;
    logic          full_x_s;
    logic          full_f_s;
    logic          start_r;
    logic          busy_r;

    // Channel enables: loading only in LOAD, release only on compute_done in RUN.
    always_comb begin
        load_en_s = (state_r == ST_LOAD);
        clear_s   = (state_r == ST_RUN) && compute_done;
    end

    load_channel #(.N(DATA_N), .LG_N(LG_DATA_N)) u_chan_x (
        .clk       (clk),
        .reset     (reset),
        .s_data_in (s_data_in_x),
        .s_valid   (s_valid_x),
        .s_ready   (s_ready_x),
        .load_en   (load_en_s),
        .clear     (clear_s),
        .rd_addr   (rd_addr_x),
        .data      (data_x),
        .addr      (addr_x),
        .wr_en     (wr_en_x),
        .full      (full_x_s)
    );

    load_channel #(.N(FILTER_N), .LG_N(LG_FILTER_N)) u_chan_f (
        .clk       (clk),
        .reset     (reset),
        .s_data_in (s_data_in_f),
        .s_valid   (s_valid_f),
        .s_ready   (s_ready_f),
        .load_en   (load_en_s),
        .clear     (clear_s),
        .rd_addr   (rd_addr_f),
        .data      (data_f),
        .addr      (addr_f),
        .wr_en     (wr_en_f),
        .full      (full_f_s)
    );

    // Next-state logic; compute_done only matters in RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (full_x_s && full_f_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_START: state_next_s = ST_RUN;
            ST_RUN: begin
                if (compute_done) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register plus start/busy, registered from the next state so
    // they line up exactly with START and START/RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            start_r <= (state_next_s == ST_START);
            busy_r  <= (state_next_s != ST_LOAD);
        end
    end

    assign start = start_r;
    assign busy  = busy_r;

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Write-side front end for the 1-D convolution datapath. It accepts sample (x) and coefficient (f) bytes on two valid/ready streams and generates the memory write interface: data, address and write enable for each memory.
- It signals the convolution controller once both memories are full.
- While a computation runs, it hands the memory address buses to the controller. It reopens for loading only when the controller reports completion.

Parameters:
DATA_N, 8, number of x samples per run
FILTER_N, 4, number of filter taps per run
LG_DATA_N, 3, address width of x memory; DATA_N <= 2**LG_DATA_N
LG_FILTER_N, 2, address width of f memory; FILTER_N <= 2**LG_FILTER_N

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_data_in_x  in  8  signed x sample
s_valid_x  in  1  x sample valid
s_ready_x  out  1  loader accepts x sample
s_data_in_f  in  8  signed filter tap
s_valid_f  in  1  filter tap valid
s_ready_f  out  1  loader accepts filter tap
rd_addr_x  in  LG_DATA_N  controller read address for x memory, used during RUN
rd_addr_f  in  LG_FILTER_N  controller read address for f memory, used during RUN
compute_done  in  1  controller pulse: run finished, memories released
data_x  out  8  write data to x memory
addr_x  out  LG_DATA_N  x memory address
wr_en_x  out  1  x memory write enable
data_f  out  8  write data to f memory
addr_f  out  LG_FILTER_N  f memory address
wr_en_f  out  1  f memory write enable
start  out  1  one-cycle pulse: both memories loaded
busy  out  1  high from START through RUN

Behaviour:
- Reset (synchronous, active-high):
  - state=LOAD, both write counters=0, full_x=full_f=0.
  - Registered outputs: start=0, busy=0.
  - After reset deassert: s_ready_x=s_ready_f=1, wr_en_x=wr_en_f=0, addr_x=addr_f=0.
  - Memory contents are not cleared. Reset mid-load discards any partial vector; the next load starts at address 0.
- Top FSM states: LOAD, START, RUN.
  - LOAD -> START when full_x && full_f.
  - START -> RUN unconditionally, after one cycle.
  - RUN -> LOAD on compute_done. This clears full_x, full_f and both counters.
  - compute_done is ignored in LOAD and START.
- Handshake:
  - s_ready_x = (state==LOAD) && !full_x; s_ready_f = (state==LOAD) && !full_f.
  - A transfer occurs when valid && ready.
  - s_ready does not depend on s_valid. s_valid may be held without transfer; no data is lost or duplicated.
- Write path (combinational, zero latency; the memory captures on the same clk edge):
  - wr_en_x = s_valid_x && s_ready_x; data_x = s_data_in_x.
  - In LOAD, addr_x = cnt_x. The f channel is identical, using cnt_f.
- Counters:
  - cnt_x increments on each x transfer.
  - On the transfer at cnt_x==DATA_N-1: cnt_x wraps to 0 and full_x sets at the next edge.
  - Same for f, using FILTER_N-1.
  - The x and f channels are independent. Either may finish first.
- Boundary cases:
  - Final x and final f transfers in the same cycle: both flags set at the same edge. start rises on the following edge, because the FSM enters START one cycle after both flags are set.
- start: high exactly during the START state, one cycle.
- busy: high in START and RUN.
- Address mux during START and RUN:
  - addr_x = rd_addr_x, addr_f = rd_addr_f.
  - wr_en_x = wr_en_f = 0 and s_ready_* = 0.
- Address width: counters are LG_* bits wide. Non-power-of-two N must still wrap at N-1.

Decomposition:
- Shared package conv_pkg:
  - loader state enum (LOAD, START, RUN)
  - data width constant (8)
- Natural sub-module: load_channel, parameterized by N and LG_N and instantiated twice. It holds the counter, full flag, ready/write-enable generation and the address mux.
- The top level holds the FSM and the start/busy outputs.

Test Plan:
- Reset, then stream x=1..8 and f=1..4 with valid held high -> wr_en_x high for 8 cycles, addr_x 0..7 with data_x 1..8 at each address; addr_f 0..3. start pulses one cycle, exactly one cycle after full_x && full_f; busy=1; both readies drop.
- Toggle s_valid_x on alternate cycles while s_valid_f stays high -> f fills in 4 cycles and x in 16; s_ready_f=0 after f fills; start only after the 8th x transfer; no duplicate addresses.
- In RUN, drive rd_addr_x=5 and rd_addr_f=2 with s_valid high -> addr_x=5, addr_f=2, wr_en=0, s_ready=0. Pulse compute_done -> next cycle LOAD, busy=0, addr_x=0, s_ready=1.
- Assert reset after 3 x and 2 f transfers -> next cycle cnt=0, full=0. The reload writes from address 0, and start requires 8 new x and 4 new f transfers.
- Pulse compute_done in LOAD and in START -> no state change; the START->RUN transition is unaffected.
- DATA_N=6, LG_DATA_N=3 -> addresses 0..5 only, wrap after the 6th transfer; address 6 is never written.
